// File: rtl/lpm_xor_accum.sv
`default_nettype none
// ============================================================================
// Module   : lpm_xor_accum
// Purpose  : Streaming XOR-fold accumulator. Words arrive over a valid/ready
//            handshake and are XOR-ed together per frame. A frame closes after
//            lpm_size beats, or earlier on a beat marked in_last. Each
//            frame's fold is presented as a single registered result word.
// Ports    : clock     - sole clock, rising edge
//            aclr      - asynchronous active-high clear
//            sclr      - synchronous active-high clear (aclr has priority)
//            data      - input word (lpm_width bits)
//            in_valid  - data/in_last valid this cycle
//            in_last   - closes the current frame on this beat
//            in_ready  - block accepts a beat this cycle
//            result    - XOR of all beats of the completed frame
//            count     - number of beats folded into result
//            out_valid - result/count hold a completed frame
//            out_ready - downstream consumes the result this cycle
// Revision : 1.0 - initial release
// ============================================================================
module lpm_xor_accum #(
    parameter int    lpm_width = 1,
    parameter int    lpm_size  = 1,
    parameter string lpm_type  = "lpm_xor_accum",
    parameter string lpm_hint  = "UNUSED"
) (
    input  logic                 clock,
    input  logic                 aclr,
    input  logic                 sclr,
    input  logic [lpm_width-1:0] data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [lpm_width-1:0] result,
    output logic [15:0]          count,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Elaboration-time parameter sanity check.
    generate
        if ((lpm_width <= 0) || (lpm_size < 1) || (lpm_size > 65535)) begin : g_param_error
            $fatal(1, "ERROR: lpm_xor_accum: illegal parameters (lpm_width must be > 0, lpm_size must be 1..65535)");
        end
    endgenerate

    // Count value at which the next accepted beat is the last one allowed.
    localparam logic [15:0] c_last_cnt = 16'(lpm_size - 1);

    logic [lpm_width-1:0] r_acc;
    logic [15:0]          r_cnt;

    logic w_accept;
    logic w_close;
    logic w_drain;

    // Stall only while a completed result is held and not being drained;
    // deliberately independent of in_valid.
    assign in_ready = !(out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_close  = in_last || (r_cnt == c_last_cnt);
    assign w_drain  = out_valid && out_ready;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            result    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else if (sclr) begin
            // Any beat presented alongside sclr is discarded.
            r_acc     <= '0;
            r_cnt     <= '0;
            result    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (w_accept && w_close) begin
                // Closing beat: output register reloads even if the previous
                // result is being drained this same cycle (full throughput).
                result    <= r_acc ^ data;
                count     <= r_cnt + 16'd1;
                out_valid <= 1'b1;
                r_acc     <= '0;
                r_cnt     <= '0;
            end else begin
                if (w_accept) begin
                    r_acc <= r_acc ^ data;
                    r_cnt <= r_cnt + 16'd1;
                end
                if (w_drain) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lpm_xor_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpm_xor_accum
// Purpose  : Self-checking bench for lpm_xor_accum (8-bit/4-beat instance plus
//            a 4-bit/1-beat instance). A frame-level reference model (queue of
//            accepted beats, folded on close) predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lpm_xor_accum;

    localparam int W    = 8;
    localparam int SIZE = 4;

    logic         clk = 1'b0;
    logic         aclr, sclr, in_valid, in_last, out_ready;
    logic [W-1:0] data;
    logic         in_ready, out_valid;
    logic [W-1:0] result;
    logic [15:0]  count;

    logic        aclr1, d1_valid, d1_last, d1_ready, d1_ovalid;
    logic [3:0]  d1_data, d1_result;
    logic [15:0] d1_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lpm_xor_accum #(.lpm_width(W), .lpm_size(SIZE)) dut (
        .clock(clk), .aclr(aclr), .sclr(sclr), .data(data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .result(result), .count(count), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    lpm_xor_accum #(.lpm_width(4), .lpm_size(1)) dut1 (
        .clock(clk), .aclr(aclr1), .sclr(1'b0), .data(d1_data),
        .in_valid(d1_valid), .in_last(d1_last), .in_ready(d1_ready),
        .result(d1_result), .count(d1_count), .out_valid(d1_ovalid),
        .out_ready(1'b1)
    );

    // Reference model state: beats of the open frame and the presented output.
    logic [W-1:0] frame_q[$];
    logic         m_valid;
    logic [W-1:0] m_res;
    int           m_cnt;

    typedef struct {
        logic [W-1:0] d[4];
        int           n;
        bit           use_last;
        logic [W-1:0] exp_res;
        int           exp_cnt;
    } frame_vec_t;

    frame_vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        frame_q.delete();
        m_valid = 1'b0;
        m_res   = '0;
        m_cnt   = 0;
    endtask

    // One clock cycle with the currently driven inputs; called at posedge+1.
    task automatic cycle();
        logic         exp_ready;
        bit           acc, drain;
        logic [W-1:0] f;
        #1;
        exp_ready = !(m_valid && !out_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (sclr) begin
            model_clear();
        end else begin
            acc   = in_valid && exp_ready;
            drain = m_valid && out_ready;
            if (acc) begin
                frame_q.push_back(data);
                if (in_last || frame_q.size() == SIZE) begin
                    f = '0;
                    foreach (frame_q[i]) f = f ^ frame_q[i];
                    m_res   = f;
                    m_cnt   = frame_q.size();
                    m_valid = 1'b1;
                    frame_q.delete();
                end else if (drain) begin
                    m_valid = 1'b0;
                end
            end else if (drain) begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("result", 32'(result), 32'(m_res));
        chk("count", 32'(count), 32'(m_cnt));
    endtask

    initial begin
        logic [W-1:0] held_res;
        logic [15:0]  held_cnt;

        tbl[0] = '{d: '{8'h01, 8'h02, 8'h04, 8'h08}, n: 4, use_last: 1'b0, exp_res: 8'h0F, exp_cnt: 4};
        tbl[1] = '{d: '{8'hFF, 8'h0F, 8'hF0, 8'hAA}, n: 4, use_last: 1'b0, exp_res: 8'hAA, exp_cnt: 4};
        tbl[2] = '{d: '{8'h3C, 8'h3C, 8'h00, 8'h00}, n: 2, use_last: 1'b1, exp_res: 8'h00, exp_cnt: 2};
        tbl[3] = '{d: '{8'h55, 8'h00, 8'h00, 8'h00}, n: 1, use_last: 1'b1, exp_res: 8'h55, exp_cnt: 1};
        tbl[4] = '{d: '{8'h12, 8'h34, 8'h56, 8'h00}, n: 3, use_last: 1'b1, exp_res: 8'h70, exp_cnt: 3};
        tbl[5] = '{d: '{8'h80, 8'h40, 8'h20, 8'h11}, n: 4, use_last: 1'b1, exp_res: 8'hF1, exp_cnt: 4};

        aclr = 1'b1; aclr1 = 1'b1; sclr = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; data = '0; out_ready = 1'b1;
        d1_valid = 1'b0; d1_last = 1'b0; d1_data = '0;
        model_clear();
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        aclr = 1'b0; aclr1 = 1'b0;

        // Two beats into a frame, then asynchronous clear between edges.
        in_valid = 1'b1; data = 8'hA5; cycle();
        data = 8'h5A; cycle();
        in_valid = 1'b0;
        aclr = 1'b1;
        #1;
        chk("aclr_out_valid", 32'(out_valid), 32'd0);
        chk("aclr_result", 32'(result), 32'd0);
        chk("aclr_count", 32'(count), 32'd0);
        chk("aclr_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        aclr = 1'b0;
        model_clear();

        // Directed frames, back to back with out_ready high.
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < tbl[t].n; k++) begin
                in_valid = 1'b1;
                data     = tbl[t].d[k];
                in_last  = tbl[t].use_last && (k == tbl[t].n - 1);
                cycle();
            end
            chk("tbl_out_valid", 32'(out_valid), 32'd1);
            chk("tbl_result", 32'(result), 32'(tbl[t].exp_res));
            chk("tbl_count", 32'(count), 32'(tbl[t].exp_cnt));
        end
        in_valid = 1'b0; in_last = 1'b0;
        cycle();

        // Backpressure: complete a frame with out_ready low, hold it 5 cycles.
        out_ready = 1'b0;
        for (int k = 0; k < SIZE; k++) begin
            in_valid = 1'b1; data = W'($urandom); cycle();
        end
        held_res = result;
        held_cnt = count;
        in_last  = 1'b1; data = 8'hC3;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result_stable", 32'(result), 32'(held_res));
            chk("bp_count_stable", 32'(count), 32'(held_cnt));
        end
        // Drain and close in the same cycle: output reloads, stays valid.
        out_ready = 1'b1;
        cycle();
        chk("reload_out_valid", 32'(out_valid), 32'd1);
        chk("reload_result", 32'(result), 32'hC3);
        chk("reload_count", 32'(count), 32'd1);
        in_valid = 1'b0; in_last = 1'b0;
        cycle();

        // Synchronous clear on the edge of an accepted closing beat.
        for (int k = 0; k < SIZE - 1; k++) begin
            in_valid = 1'b1; data = W'($urandom); cycle();
        end
        data = 8'h7E; sclr = 1'b1;
        cycle();
        sclr = 1'b0; in_valid = 1'b0;
        chk("sclr_out_valid", 32'(out_valid), 32'd0);
        chk("sclr_result", 32'(result), 32'd0);
        chk("sclr_count", 32'(count), 32'd0);
        cycle();

        // Single-beat frames: every beat is its own result.
        for (int k = 0; k < 16; k++) begin
            d1_valid = 1'b1;
            d1_data  = 4'(k);
            d1_last  = k[0];
            #1;
            chk("s1_in_ready", 32'(d1_ready), 32'd1);
            @(posedge clk); #1;
            chk("s1_out_valid", 32'(d1_ovalid), 32'd1);
            chk("s1_result", 32'(d1_result), 32'(k));
            chk("s1_count", 32'(d1_count), 32'd1);
        end
        d1_valid = 1'b0;

        // Randomised traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 4) == 0);
            data      = W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            sclr      = ($urandom_range(0, 40) == 0);
            cycle();
        end
        sclr = 1'b0; in_valid = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
